// File: rtl/chunked_tree_add_seq.sv
// Multi-cycle wide adder: one CHUNK-bit black-cell slice per cycle,
// inter-slice carry and group G/P accumulated in registers.
module chunked_tree_add_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             group_generate,
  output logic             group_propagate,
  output logic             busy
);

  localparam int CSAFE  = (CHUNK < 1) ? 1 : CHUNK;
  localparam int NCHUNK = WIDTH / CSAFE;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  generate
    if ((CHUNK < 1) || ((WIDTH % CSAFE) != 0)) begin : g_bad_cfg
      $error("chunked_tree_add_seq: CHUNK must be >= 1 and divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [KW-1:0]    k_q, k_d;
  logic             carry_q, carry_d;
  logic             gacc_q, gacc_d;
  logic             pacc_q, pacc_d;
  logic             cout_q, cout_d;
  logic             gg_q, gg_d;
  logic             gp_q, gp_d;

  // Slice datapath: operands are shifted down so the live slice is at LSB
  logic [CHUNK-1:0] sl_a, sl_b, sl_g, sl_p, sl_sum;
  logic             c_int;
  logic             sl_gk;
  logic             sl_pk;

  always_comb begin
    sl_a   = a_q[CHUNK-1:0];
    sl_b   = b_q[CHUNK-1:0];
    sl_g   = sl_a & sl_b;
    sl_p   = sl_a ^ sl_b;
    c_int  = carry_q;
    sl_gk  = 1'b0;
    sl_pk  = 1'b1;
    sl_sum = '0;
    for (int i = 0; i < CHUNK; i++) begin
      sl_sum[i] = sl_p[i] ^ c_int;
      c_int     = sl_g[i] | (sl_p[i] & c_int);
      sl_gk     = sl_g[i] | (sl_p[i] & sl_gk);
      sl_pk     = sl_pk & sl_p[i];
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    shadow_d = shadow_q;
    sum_d    = sum_q;
    k_d      = k_q;
    carry_d  = carry_q;
    gacc_d   = gacc_q;
    pacc_d   = pacc_q;
    cout_d   = cout_q;
    gg_d     = gg_q;
    gp_d     = gp_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          k_d     = '0;
          gacc_d  = 1'b0;
          pacc_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d      = a_q >> CHUNK;
        b_d      = b_q >> CHUNK;
        shadow_d = (shadow_q >> CHUNK)
                 | (WIDTH'(sl_sum) << (WIDTH - CHUNK));
        carry_d  = sl_gk | (sl_pk & carry_q);
        gacc_d   = sl_gk | (sl_pk & gacc_q);
        pacc_d   = sl_pk & pacc_q;
        if (k_q == KW'(NCHUNK - 1)) begin
          k_d     = '0;
          sum_d   = shadow_d;
          cout_d  = carry_d;
          gg_d    = gacc_d;
          gp_d    = pacc_d;
          state_d = S_DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      shadow_q <= '0;
      sum_q    <= '0;
      k_q      <= '0;
      carry_q  <= 1'b0;
      gacc_q   <= 1'b0;
      pacc_q   <= 1'b1;
      cout_q   <= 1'b0;
      gg_q     <= 1'b0;
      gp_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      shadow_q <= shadow_d;
      sum_q    <= sum_d;
      k_q      <= k_d;
      carry_q  <= carry_d;
      gacc_q   <= gacc_d;
      pacc_q   <= pacc_d;
      cout_q   <= cout_d;
      gg_q     <= gg_d;
      gp_q     <= gp_d;
    end
  end

  assign in_ready        = (state_q == S_IDLE);
  assign out_valid       = (state_q == S_DONE);
  assign busy            = (state_q != S_IDLE);
  assign sum             = sum_q;
  assign cout            = cout_q;
  assign group_generate  = gg_q;
  assign group_propagate = gp_q;

endmodule

// File: tb/tb_chunked_tree_add_seq.sv
// Bench for chunked_tree_add_seq: directed cases plus randomized ops
// against an arithmetic reference, on a 32/8 and an 8/8 instance.
module tb_chunked_tree_add_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        iv, ir, ci, ov, ordy, co, gg, gp, bsy;
  logic [31:0] a, b, s;
  logic        iv8, ir8, ci8, ov8, ordy8, co8, gg8, gp8, bsy8;
  logic [7:0]  a8, b8, s8;

  int tests = 0;
  int fails = 0;

  chunked_tree_add_seq #(.WIDTH(32), .CHUNK(8)) dut32 (
    .clk(clk), .rst(rst),
    .in_valid(iv), .in_ready(ir),
    .a(a), .b(b), .cin(ci),
    .out_valid(ov), .out_ready(ordy),
    .sum(s), .cout(co),
    .group_generate(gg), .group_propagate(gp),
    .busy(bsy)
  );

  chunked_tree_add_seq #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(iv8), .in_ready(ir8),
    .a(a8), .b(b8), .cin(ci8),
    .out_valid(ov8), .out_ready(ordy8),
    .sum(s8), .cout(co8),
    .group_generate(gg8), .group_propagate(gp8),
    .busy(bsy8)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ov32(output int n);
    n = 0;
    while (!ov && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic op32(input logic [31:0] ta, input logic [31:0] tb_,
                      input logic tc, input int stall);
    logic [32:0] full;
    logic [32:0] nocin;
    logic        ep;
    int          n;
    full  = {1'b0, ta} + {1'b0, tb_} + 33'(tc);
    nocin = {1'b0, ta} + {1'b0, tb_};
    ep    = ((ta ^ tb_) == 32'hFFFF_FFFF);
    n = 0;
    while (!ir && n < 40) begin
      tick();
      n++;
    end
    chk("in_ready_wait", ir, 1);
    iv = 1'b1; a = ta; b = tb_; ci = tc;
    tick();
    iv = 1'b0; a = $urandom; b = $urandom; ci = 1'($urandom_range(0, 1));
    wait_ov32(n);
    chk("latency32", n, 4);
    chk("out_valid32", ov, 1);
    chk("sum32", s, full[31:0]);
    chk("cout32", co, full[32]);
    chk("gg32", gg, nocin[32]);
    chk("gp32", gp, ep);
    chk("invariant32", co, gg | (gp & tc));
    for (int i = 0; i < stall; i++) begin
      tick();
      chk("stall_ov32", ov, 1);
      chk("stall_sum32", s, full[31:0]);
    end
    ordy = 1'b1;
    tick();
    ordy = 1'b0;
    chk("ov_after_hs32", ov, 0);
    chk("sum_hold32", s, full[31:0]);
  endtask

  task automatic op8(input logic [7:0] ta, input logic [7:0] tb_,
                     input logic tc, input int stall);
    logic [8:0] full;
    logic [8:0] nocin;
    int         n;
    full  = {1'b0, ta} + {1'b0, tb_} + 9'(tc);
    nocin = {1'b0, ta} + {1'b0, tb_};
    chk("in_ready8", ir8, 1);
    iv8 = 1'b1; a8 = ta; b8 = tb_; ci8 = tc;
    tick();
    iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    n = 0;
    while (!ov8 && n < 40) begin
      tick();
      n++;
    end
    chk("latency8", n, 1);
    chk("sum8", s8, full[7:0]);
    chk("cout8", co8, full[8]);
    chk("gg8", gg8, nocin[8]);
    chk("gp8", gp8, ((ta ^ tb_) == 8'hFF));
    repeat (stall) tick();
    chk("stall_ov8", ov8, 1);
    ordy8 = 1'b1;
    tick();
    ordy8 = 1'b0;
    chk("ov_after_hs8", ov8, 0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    int          n;
    rst = 1'b1;
    iv = 0; a = 0; b = 0; ci = 0; ordy = 0;
    iv8 = 0; a8 = 0; b8 = 0; ci8 = 0; ordy8 = 0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_in_ready", ir, 1);
    chk("rst_out_valid", ov, 0);
    chk("rst_sum", s, 0);
    chk("rst_cout", co, 0);
    chk("rst_gg", gg, 0);
    chk("rst_gp", gp, 0);
    chk("rst_busy", bsy, 0);
    chk("rst_in_ready8", ir8, 1);

    op32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
    op32(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1);
    op32(32'h1234_5678, 32'h0FED_CBA8, 1'b0, 0);
    op32(32'h8000_0000, 32'h8000_0000, 1'b0, 0);

    // backpressure with a held in_valid that must be ignored
    iv = 1'b1; a = 32'd1; b = 32'd2; ci = 1'b0;
    tick();
    a = 32'd5; b = 32'd5;
    wait_ov32(n);
    chk("bp_latency", n, 4);
    for (int i = 0; i < 5; i++) begin
      chk("bp_ov", ov, 1);
      chk("bp_sum", s, 32'd3);
      chk("bp_in_ready", ir, 0);
      tick();
    end
    ordy = 1'b1;
    tick();
    ordy = 1'b0;
    chk("bp_in_ready_after", ir, 1);
    chk("bp_ov_after", ov, 0);
    tick();
    iv = 1'b0;
    chk("bp_accept_busy", bsy, 1);
    chk("bp_accept_ready", ir, 0);
    wait_ov32(n);
    chk("bp_second_sum", s, 32'd10);
    ordy = 1'b1;
    tick();
    ordy = 1'b0;

    // reset during the second RUN cycle
    iv = 1'b1; a = 32'd7; b = 32'd9; ci = 1'b0;
    tick();
    iv = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_ready", ir, 1);
    chk("mid_rst_busy", bsy, 0);
    chk("mid_rst_ov", ov, 0);
    chk("mid_rst_sum", s, 0);
    repeat (5) tick();
    chk("mid_rst_no_output", ov, 0);
    op32(32'd1, 32'd1, 1'b0, 0);

    op8(8'h80, 8'h80, 1'b0, 0);
    op8(8'hFF, 8'h00, 1'b1, 2);

    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = ~ra;
        1: rb = ~ra ^ (32'h1 << $urandom_range(0, 31));
        default: rb = $urandom;
      endcase
      ordy = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) tick();
      ordy = 1'b0;
      op32(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    for (int i = 0; i < 300; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ~ra : $urandom;
      repeat ($urandom_range(0, 2)) tick();
      op8(ra[7:0], rb[7:0], 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
